// File: rtl/rgmii_pkg.sv
// Shared encodings for the RGMII receive adapter: speed codes, FSM states,
// in-band status bit positions and the GMII beat carried down the output pipe.
package rgmii_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SPD_W  = 2;

  localparam logic [SPD_W-1:0] SPD_10   = 2'b00;
  localparam logic [SPD_W-1:0] SPD_100  = 2'b01;
  localparam logic [SPD_W-1:0] SPD_1000 = 2'b10;

  // Bit positions of the in-band status fields in the rising-edge nibble
  localparam int unsigned STS_LINK   = 0;
  localparam int unsigned STS_SPD    = 1;
  localparam int unsigned STS_DUPLEX = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_G_DATA = 2'd1,
    ST_N_LO   = 2'd2,
    ST_N_HI   = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic              dv;
    logic              en;
    logic              er;
    logic [BYTE_W-1:0] rxd;
  } gmii_beat_t;

  // The reserved code 11 runs as 1000M
  function automatic logic [SPD_W-1:0] norm_speed(input logic [SPD_W-1:0] s);
    return (s == SPD_10 || s == SPD_100) ? s : SPD_1000;
  endfunction

endpackage

// File: rtl/rgmii_inband_status.sv
// In-band link status decode with a two-sample debounce.
module rgmii_inband_status
  import rgmii_pkg::*;
(
  input  logic             gmii_rx_clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [NIB_W-1:0] rxd_nib,
  output logic             link_up,
  output logic [SPD_W-1:0] link_speed,
  output logic             link_duplex
);

  logic [NIB_W-1:0] cand_q;
  logic             cand_vld_q;

  // Publish a status nibble only once it repeats on back-to-back qualifying cycles
  always_ff @(posedge gmii_rx_clk) begin
    if (!rst_n) begin
      cand_q      <= '0;
      cand_vld_q  <= 1'b0;
      link_up     <= 1'b0;
      link_speed  <= '0;
      link_duplex <= 1'b0;
    end else if (sample_en) begin
      cand_q     <= rxd_nib;
      cand_vld_q <= 1'b1;
      if (cand_vld_q && (rxd_nib == cand_q)) begin
        link_up     <= rxd_nib[STS_LINK];
        link_speed  <= rxd_nib[STS_SPD +: SPD_W];
        link_duplex <= rxd_nib[STS_DUPLEX];
      end
    end else begin
      cand_vld_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rgmii_rx_adapt.sv
// RGMII receive adapter: IDDR nibble pairs to GMII bytes for 1000M (DDR) and
// 10/100M (SDR nibble pairing), with in-band status and frame statistics.
module rgmii_rx_adapt
  import rgmii_pkg::*;
#(
  parameter int unsigned OUT_PIPE     = 1,
  parameter bit          INBAND_SPEED = 1'b0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              gmii_rx_clk,
  input  logic              rst_n,
  input  logic [NIB_W-1:0]  ddr_rxd_r,
  input  logic [NIB_W-1:0]  ddr_rxd_f,
  input  logic              ddr_ctl_r,
  input  logic              ddr_ctl_f,
  input  logic [SPD_W-1:0]  speed_sel,
  input  logic              stat_clr,
  output logic              gmii_rx_dv,
  output logic              gmii_rx_en,
  output logic              gmii_rx_er,
  output logic [BYTE_W-1:0] gmii_rxd,
  output logic              link_up,
  output logic [SPD_W-1:0]  link_speed,
  output logic              link_duplex,
  output logic [SPD_W-1:0]  speed_act,
  output logic [CNT_W-1:0]  rx_frame_cnt,
  output logic [CNT_W-1:0]  rx_err_cnt
);

  rx_state_e        state_q, state_d;
  gmii_beat_t       beat_d;
  gmii_beat_t       pipe_q [OUT_PIPE+1];
  logic [NIB_W-1:0] lo_q, lo_d;
  logic             er_lo_q, er_lo_d;
  logic             frm_err_q, frm_err_d;
  logic             frame_end_c, frame_bad_c;
  logic             dv_c, er_c;

  assign dv_c = ddr_ctl_r;
  assign er_c = ddr_ctl_r ^ ddr_ctl_f;

  // In-band status is only meaningful between frames with no error signalled
  rgmii_inband_status u_inband (
    .gmii_rx_clk (gmii_rx_clk),
    .rst_n       (rst_n),
    .sample_en   (!dv_c && !er_c),
    .rxd_nib     (ddr_rxd_r),
    .link_up     (link_up),
    .link_speed  (link_speed),
    .link_duplex (link_duplex)
  );

  // Speed only follows its source while idle, so a frame never changes mode
  always_ff @(posedge gmii_rx_clk) begin
    if (!rst_n) begin
      speed_act <= SPD_1000;
    end else if (state_q == ST_IDLE && !dv_c) begin
      speed_act <= norm_speed(INBAND_SPEED ? link_speed : speed_sel);
    end
  end

  // FSM state register
  always_ff @(posedge gmii_rx_clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Nibble and frame-error holding registers
  always_ff @(posedge gmii_rx_clk) begin
    if (!rst_n) begin
      lo_q      <= '0;
      er_lo_q   <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      lo_q      <= lo_d;
      er_lo_q   <= er_lo_d;
      frm_err_q <= frm_err_d;
    end
  end

  // Next state and core beat; the first dv cycle in IDLE is already frame data
  always_comb begin
    state_d     = state_q;
    beat_d      = '0;
    lo_d        = lo_q;
    er_lo_d     = er_lo_q;
    frm_err_d   = frm_err_q;
    frame_end_c = 1'b0;
    frame_bad_c = 1'b0;
    beat_d.dv   = dv_c;
    case (state_q)
      ST_IDLE: begin
        if (dv_c) begin
          frm_err_d = er_c;
          if (speed_act == SPD_1000) begin
            beat_d.en  = 1'b1;
            beat_d.er  = er_c;
            beat_d.rxd = {ddr_rxd_f, ddr_rxd_r};
            state_d    = ST_G_DATA;
          end else begin
            lo_d    = ddr_rxd_r;
            er_lo_d = er_c;
            state_d = ST_N_HI;
          end
        end
      end
      ST_G_DATA: begin
        if (dv_c) begin
          beat_d.en  = 1'b1;
          beat_d.er  = er_c;
          beat_d.rxd = {ddr_rxd_f, ddr_rxd_r};
          frm_err_d  = frm_err_q | er_c;
        end else begin
          frame_end_c = 1'b1;
          frame_bad_c = frm_err_q;
          state_d     = ST_IDLE;
        end
      end
      ST_N_LO: begin
        if (dv_c) begin
          lo_d      = ddr_rxd_r;
          er_lo_d   = er_c;
          frm_err_d = frm_err_q | er_c;
          state_d   = ST_N_HI;
        end else begin
          frame_end_c = 1'b1;
          frame_bad_c = frm_err_q;
          state_d     = ST_IDLE;
        end
      end
      ST_N_HI: begin
        if (dv_c) begin
          beat_d.en  = 1'b1;
          beat_d.er  = er_lo_q | er_c;
          beat_d.rxd = {ddr_rxd_r, lo_q};
          frm_err_d  = frm_err_q | er_c;
          state_d    = ST_N_LO;
        end else begin
          // Odd nibble count: the dangling nibble is dropped
          frame_end_c = 1'b1;
          frame_bad_c = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Core register followed by OUT_PIPE delay stages
  always_ff @(posedge gmii_rx_clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= OUT_PIPE; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= beat_d;
      for (int i = 1; i <= OUT_PIPE; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign gmii_rx_dv = pipe_q[OUT_PIPE].dv;
  assign gmii_rx_en = pipe_q[OUT_PIPE].en;
  assign gmii_rx_er = pipe_q[OUT_PIPE].er;
  assign gmii_rxd   = pipe_q[OUT_PIPE].rxd;

  // Saturating statistics; clear wins over a same-cycle increment
  always_ff @(posedge gmii_rx_clk) begin
    if (!rst_n || stat_clr) begin
      rx_frame_cnt <= '0;
      rx_err_cnt   <= '0;
    end else begin
      if (frame_end_c && (rx_frame_cnt != '1))
        rx_frame_cnt <= rx_frame_cnt + CNT_W'(1);
      if (frame_end_c && frame_bad_c && (rx_err_cnt != '1))
        rx_err_cnt <= rx_err_cnt + CNT_W'(1);
    end
  end

endmodule
